// File: rtl/elevator_dispatcher.sv
// Call scheduler and motion sequencer for a 3-floor elevator car.
// Latches calls, runs a keep-direction (collective-selective) policy, and times the door dwell.
module elevator_dispatcher #(
  parameter int DOOR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] floor_sensor,
  input  logic [2:0] car_call,
  input  logic [2:0] hall_up,
  input  logic [2:0] hall_dn,
  output logic [1:0] ac,
  output logic [1:0] display,
  output logic       door_open,
  output logic [2:0] pending,
  output logic       fault
);

  localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DN, DOOR, HALT} state_t;

  state_t        state, state_nx;
  logic [1:0]    floor, floor_nx, arr;
  logic          dir_up, dir_up_nx, fault_nx, further, stop;
  logic [CW-1:0] dwell, dwell_nx;
  logic [2:0]    car_q, up_q, dn_q, all_q;
  logic [2:0]    car_clr, up_clr, dn_clr, block, here_btn, here_reg, arr_oh;
  logic [2:0]    hall_up_m, hall_dn_m;

  function automatic logic [2:0] onehot(input logic [1:0] f);
    case (f)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic above(input logic [1:0] f, input logic [2:0] c);
    case (f)
      2'd1:    return c[2] | c[1];
      2'd2:    return c[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic below(input logic [1:0] f, input logic [2:0] c);
    case (f)
      2'd3:    return c[1] | c[0];
      2'd2:    return c[0];
      default: return 1'b0;
    endcase
  endfunction

  assign hall_up_m = hall_up & 3'b011;
  assign hall_dn_m = hall_dn & 3'b110;
  assign all_q     = car_q | up_q | dn_q;
  assign here_btn  = (car_call | hall_up_m | hall_dn_m) & onehot(floor);
  assign here_reg  = all_q & onehot(floor);

  always_comb begin
    state_nx  = state;
    floor_nx  = floor;
    dir_up_nx = dir_up;
    dwell_nx  = dwell;
    fault_nx  = fault;
    car_clr   = 3'b000;
    up_clr    = 3'b000;
    dn_clr    = 3'b000;
    arr       = 2'd0;
    arr_oh    = 3'b000;
    further   = 1'b0;
    stop      = 1'b0;
    if (state == HALT)
      block = 3'b111;
    else if (state == IDLE || state == DOOR)
      block = onehot(floor);
    else
      block = 3'b000;

    case (state)
      IDLE: begin
        if (|(here_btn | here_reg)) begin
          state_nx = DOOR;
          dwell_nx = CW'(DOOR_CYCLES - 1);
          car_clr  = onehot(floor);
          up_clr   = onehot(floor);
          dn_clr   = onehot(floor);
        end else if (above(floor, all_q)) begin
          state_nx  = MOVE_UP;
          dir_up_nx = 1'b1;
        end else if (below(floor, all_q)) begin
          state_nx  = MOVE_DN;
          dir_up_nx = 1'b0;
        end
      end
      MOVE_UP, MOVE_DN: begin
        arr    = (state == MOVE_UP) ? floor + 2'd1 : floor - 2'd1;
        arr_oh = onehot(arr);
        // A sensor still showing the floor just left is a wide pulse, not an error.
        if (floor_sensor == 3'b000 || floor_sensor == onehot(floor)) begin
          state_nx = state;
        end else if (floor_sensor != arr_oh) begin
          fault_nx = 1'b1;
          state_nx = HALT;
        end else begin
          floor_nx = arr;
          further  = (state == MOVE_UP) ? above(arr, all_q) : below(arr, all_q);
          stop     = |(car_q & arr_oh) | ~further |
                     ((state == MOVE_UP) ? |(up_q & arr_oh) : |(dn_q & arr_oh));
          if (stop) begin
            state_nx = DOOR;
            dwell_nx = CW'(DOOR_CYCLES - 1);
            car_clr  = arr_oh;
            if (state == MOVE_UP) up_clr = arr_oh;
            else                  dn_clr = arr_oh;
            if (!further) begin
              if (state == MOVE_UP) dn_clr = arr_oh;
              else                  up_clr = arr_oh;
              dir_up_nx = (state == MOVE_DN);
            end
          end
        end
      end
      DOOR: begin
        if (|here_btn) begin
          dwell_nx = CW'(DOOR_CYCLES - 1);
        end else if (dwell == '0) begin
          if (dir_up ? above(floor, all_q) : below(floor, all_q)) begin
            state_nx = dir_up ? MOVE_UP : MOVE_DN;
          end else if (dir_up ? below(floor, all_q) : above(floor, all_q)) begin
            dir_up_nx = ~dir_up;
            state_nx  = dir_up ? MOVE_DN : MOVE_UP;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          dwell_nx = dwell - CW'(1);
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // Clear beats a same-edge set so a served call never lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      floor   <= 2'd1;
      dir_up  <= 1'b1;
      dwell   <= '0;
      fault   <= 1'b0;
      car_q   <= 3'b000;
      up_q    <= 3'b000;
      dn_q    <= 3'b000;
      pending <= 3'b000;
    end else begin
      state   <= state_nx;
      floor   <= floor_nx;
      dir_up  <= dir_up_nx;
      dwell   <= dwell_nx;
      fault   <= fault_nx;
      car_q   <= (car_q | (car_call & ~block)) & ~car_clr;
      up_q    <= (up_q | (hall_up_m & ~block)) & ~up_clr;
      dn_q    <= (dn_q | (hall_dn_m & ~block)) & ~dn_clr;
      pending <= all_q;
    end
  end

  always_comb begin
    ac = 2'b00;
    case (state)
      MOVE_UP: ac = 2'b01;
      MOVE_DN: ac = 2'b10;
      default: ac = 2'b00;
    endcase
  end

  assign door_open = (state == DOOR);
  assign display   = floor;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed self-checking bench for elevator_dispatcher.
// Expected values are hand-derived from the call/stop/dwell rules of the dispatcher.
module tb_elevator_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] floor_sensor, car_call, hall_up, hall_dn;
  logic [1:0] ac, display;
  logic       door_open, fault;
  logic [2:0] pending;

  int vectors = 0;
  int miscompares = 0;

  elevator_dispatcher #(.DOOR_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .floor_sensor(floor_sensor), .car_call(car_call),
    .hall_up(hall_up), .hall_dn(hall_dn), .ac(ac), .display(display),
    .door_open(door_open), .pending(pending), .fault(fault)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single-call trip: press, start moving, arrive on sensor, sit out the dwell to IDLE.
  task automatic travel(input logic [2:0] call, input logic [2:0] sensor);
    car_call = call;
    tick();
    car_call = 3'b000;
    tick();
    floor_sensor = sensor;
    tick();
    floor_sensor = 3'b000;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    floor_sensor = 3'b000;
    car_call = 3'b000;
    hall_up = 3'b000;
    hall_dn = 3'b000;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_ac", ac, 2'b00);
    check("rst_display", display, 2'd1);
    check("rst_door", door_open, 1'b0);
    check("rst_pending", pending, 3'b000);
    check("rst_fault", fault, 1'b0);

    $display("[TB] scenario 1: hall_up floor 2");
    hall_up = 3'b010;
    tick();
    hall_up = 3'b000;
    check("s1_pending_lag", pending, 3'b000);
    tick();
    check("s1_pending", pending, 3'b010);
    check("s1_ac_up", ac, 2'b01);
    floor_sensor = 3'b010;
    tick();
    floor_sensor = 3'b000;
    check("s1_display", display, 2'd2);
    check("s1_ac_stop", ac, 2'b00);
    check("s1_door_c1", door_open, 1'b1);
    tick();
    check("s1_pending_clr", pending, 3'b000);
    check("s1_door_c2", door_open, 1'b1);
    tick();
    check("s1_door_c3", door_open, 1'b1);
    tick();
    check("s1_door_c4", door_open, 1'b1);
    tick();
    check("s1_door_off", door_open, 1'b0);
    check("s1_idle_ac", ac, 2'b00);

    travel(3'b001, 3'b001);
    check("to_f1_display", display, 2'd1);

    $display("[TB] scenario 2: hall_dn floor 3 then car call floor 2");
    hall_dn = 3'b100;
    tick();
    hall_dn = 3'b000;
    tick();
    check("s2_ac_up", ac, 2'b01);
    car_call = 3'b010;
    tick();
    car_call = 3'b000;
    tick();
    check("s2_pending", pending, 3'b110);
    floor_sensor = 3'b010;
    tick();
    floor_sensor = 3'b000;
    check("s2_stop2_display", display, 2'd2);
    check("s2_stop2_door", door_open, 1'b1);
    check("s2_stop2_ac", ac, 2'b00);
    tick();
    check("s2_pending_f3", pending, 3'b100);
    repeat (2) tick();
    check("s2_door_c4", door_open, 1'b1);
    tick();
    check("s2_continue_ac", ac, 2'b01);
    check("s2_continue_door", door_open, 1'b0);
    floor_sensor = 3'b100;
    tick();
    floor_sensor = 3'b000;
    check("s2_stop3_display", display, 2'd3);
    check("s2_stop3_door", door_open, 1'b1);
    tick();
    check("s2_pending_clr", pending, 3'b000);
    repeat (3) tick();
    check("s2_idle_door", door_open, 1'b0);
    check("s2_idle_ac", ac, 2'b00);
    check("s2_idle_display", display, 2'd3);

    $display("[TB] scenario 3: floor 3 to floor 1 passing floor 2");
    car_call = 3'b001;
    tick();
    car_call = 3'b000;
    tick();
    check("s3_ac_dn", ac, 2'b10);
    floor_sensor = 3'b010;
    tick();
    check("s3_pass_display", display, 2'd2);
    check("s3_pass_ac", ac, 2'b10);
    check("s3_pass_door", door_open, 1'b0);
    floor_sensor = 3'b001;
    tick();
    floor_sensor = 3'b000;
    check("s3_stop_display", display, 2'd1);
    check("s3_stop_ac", ac, 2'b00);
    check("s3_stop_door", door_open, 1'b1);
    tick();
    check("s3_pending", pending, 3'b000);
    repeat (3) tick();

    $display("[TB] scenario 4: dwell restart at floor 2");
    car_call = 3'b010;
    tick();
    car_call = 3'b000;
    tick();
    floor_sensor = 3'b010;
    tick();
    floor_sensor = 3'b000;
    repeat (2) tick();
    car_call = 3'b010;
    tick();
    car_call = 3'b000;
    check("s4_restart_door", door_open, 1'b1);
    tick();
    check("s4_not_latched", pending, 3'b000);
    check("s4_door_r2", door_open, 1'b1);
    repeat (2) tick();
    check("s4_door_r4", door_open, 1'b1);
    tick();
    check("s4_door_off", door_open, 1'b0);

    travel(3'b001, 3'b001);
    check("to_f1b_display", display, 2'd1);

    $display("[TB] scenario 5: wrong sensor while moving up");
    car_call = 3'b100;
    tick();
    car_call = 3'b000;
    tick();
    check("s5_ac_up", ac, 2'b01);
    floor_sensor = 3'b100;
    tick();
    floor_sensor = 3'b000;
    check("s5_fault", fault, 1'b1);
    check("s5_ac", ac, 2'b00);
    check("s5_door", door_open, 1'b0);
    check("s5_display", display, 2'd1);
    car_call = 3'b010;
    hall_up = 3'b001;
    tick();
    car_call = 3'b000;
    hall_up = 3'b000;
    repeat (2) tick();
    check("s5_calls_ignored", pending, 3'b100);
    check("s5_halt_ac", ac, 2'b00);
    check("s5_fault_sticky", fault, 1'b1);

    $display("[TB] scenario 6: async reset mid-move");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_fault_cleared", fault, 1'b0);
    car_call = 3'b100;
    tick();
    car_call = 3'b000;
    tick();
    floor_sensor = 3'b010;
    tick();
    floor_sensor = 3'b000;
    check("s6_pass_display", display, 2'd2);
    check("s6_pass_ac", ac, 2'b01);
    check("s6_pass_pending", pending, 3'b100);
    #3 rst = 1'b1;
    #1;
    check("s6_rst_ac", ac, 2'b00);
    check("s6_rst_display", display, 2'd1);
    check("s6_rst_pending", pending, 3'b000);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
